// File: rtl/timer_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_scheduler_if
// Brief    : Arm-request handshake bundle for the shared timer scheduler.
// Revision : 1.0
// ============================================================================
interface timer_scheduler_if #(
    parameter int NUM_TIMERS = 4,
    parameter int TS_W       = 8
);
    localparam int IDW = $clog2(NUM_TIMERS);

    logic            arm_valid;
    logic            arm_ready;
    logic [IDW-1:0]  arm_id;
    logic [TS_W-1:0] arm_value;

    modport master (
        output arm_valid,
        output arm_id,
        output arm_value,
        input  arm_ready
    );

    modport slave (
        input  arm_valid,
        input  arm_id,
        input  arm_value,
        output arm_ready
    );
endinterface
`default_nettype wire

// File: rtl/timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : timer_scheduler
// Brief    : One prescaler and one shared decrement engine sweeping NUM_TIMERS
//            countdown timers, one timer per clock on every prescaled tick.
// Revision : 1.0
// ============================================================================
module timer_scheduler #(
    parameter int NUM_TIMERS = 4,
    parameter int TS_W       = 8,
    parameter int DIVISOR    = 50000000
) (
    input  wire logic                          clk,
    input  wire logic                          reset_in,
    timer_scheduler_if.slave                   arm,
    input  wire logic [NUM_TIMERS-1:0]         expired_clr,
    input  wire logic [$clog2(NUM_TIMERS)-1:0] rd_id,
    output logic      [TS_W-1:0]               rd_count,
    output logic      [NUM_TIMERS-1:0]         timeup_out,
    output logic      [NUM_TIMERS-1:0]         expired,
    output logic                               irq,
    output logic                               tick_overrun
);
    localparam int IDW = $clog2(NUM_TIMERS);
    localparam int PW  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    localparam logic [PW-1:0]         c_PRESC_MAX = PW'(DIVISOR - 1);
    localparam logic [IDW-1:0]        c_LAST_IDX  = IDW'(NUM_TIMERS - 1);
    localparam logic [NUM_TIMERS-1:0] c_ONE       = NUM_TIMERS'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t                r_state;
    logic [IDW-1:0]        r_idx;
    logic                  r_pending;
    logic                  r_overrun;
    logic [PW-1:0]         r_presc;
    logic [TS_W-1:0]       r_count [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] r_timeup;
    logic [NUM_TIMERS-1:0] r_expired;
    logic                  r_irq;
    logic [TS_W-1:0]       r_rd_count;

    logic                  w_tick;
    logic                  w_arm_fire;
    logic                  w_arm_zero;
    logic [NUM_TIMERS-1:0] w_arm_oh;
    logic [NUM_TIMERS-1:0] w_idx_oh;
    logic                  w_dec;
    logic [TS_W-1:0]       w_dec_val;
    logic                  w_sweep_exp;
    logic [NUM_TIMERS-1:0] w_set_exp;
    logic [NUM_TIMERS-1:0] w_clr_exp;
    logic [NUM_TIMERS-1:0] w_tu_set;
    logic [NUM_TIMERS-1:0] w_tu_clr;

    always_comb begin
        w_tick      = (r_presc == c_PRESC_MAX);
        w_arm_fire  = arm.arm_valid && (r_state == S_IDLE);
        w_arm_zero  = (arm.arm_value == '0);
        w_arm_oh    = c_ONE << arm.arm_id;
        w_idx_oh    = c_ONE << r_idx;
        w_dec       = (r_state == S_SWEEP) && r_timeup[r_idx];
        w_dec_val   = r_count[r_idx] - TS_W'(1);
        // A running timer always holds a non-zero count, so reaching 1 means this decrement expires it
        w_sweep_exp = w_dec && (r_count[r_idx] == TS_W'(1));
        w_set_exp   = ((w_arm_fire && w_arm_zero) ? w_arm_oh : '0)
                    | (w_sweep_exp ? w_idx_oh : '0);
        w_clr_exp   = expired_clr
                    | ((w_arm_fire && !w_arm_zero) ? w_arm_oh : '0);
        w_tu_set    = (w_arm_fire && !w_arm_zero) ? w_arm_oh : '0;
        w_tu_clr    = ((w_arm_fire && w_arm_zero) ? w_arm_oh : '0)
                    | (w_sweep_exp ? w_idx_oh : '0);
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_pending  <= 1'b0;
            r_overrun  <= 1'b0;
            r_presc    <= '0;
            r_timeup   <= '0;
            r_expired  <= '0;
            r_irq      <= 1'b0;
            r_rd_count <= '0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            r_presc    <= w_tick ? '0 : r_presc + PW'(1);
            r_timeup   <= (r_timeup & ~w_tu_clr) | w_tu_set;
            r_expired  <= (r_expired & ~w_clr_exp) | w_set_exp;
            r_irq      <= |r_expired;
            r_rd_count <= r_count[rd_id];

            if (w_arm_fire) begin
                r_count[arm.arm_id] <= arm.arm_value;
            end else if (w_dec) begin
                r_count[r_idx] <= w_dec_val;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_tick || r_pending) begin
                        r_state   <= S_SWEEP;
                        r_idx     <= '0;
                        r_pending <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    // Only one tick can be queued; a second one is dropped and flagged
                    if (w_tick) begin
                        if (r_pending) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_pending <= 1'b1;
                        end
                    end
                    if (r_idx == c_LAST_IDX) begin
                        r_idx <= '0;
                        if (r_pending) begin
                            r_pending <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_idx <= r_idx + IDW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign arm.arm_ready = (r_state == S_IDLE);
    assign rd_count      = r_rd_count;
    assign timeup_out    = r_timeup;
    assign expired       = r_expired;
    assign irq           = r_irq;
    assign tick_overrun  = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_timer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_scheduler
// Brief    : Self-checking bench: directed and random stimulus against a
//            behavioural model, plus a fast-divisor instance for overrun.
// Revision : 1.0
// ============================================================================
module tb_timer_scheduler;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int DIV = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Main instance, DIVISOR = 8
    logic         rst1;
    logic [N-1:0] clr1, tu1, exp1;
    logic [1:0]   rd1;
    logic [W-1:0] rc1;
    logic         irq1, ovr1;
    timer_scheduler_if #(.NUM_TIMERS(N), .TS_W(W)) a1 ();
    timer_scheduler #(.NUM_TIMERS(N), .TS_W(W), .DIVISOR(DIV)) u_dut (
        .clk(clk), .reset_in(rst1), .arm(a1), .expired_clr(clr1), .rd_id(rd1),
        .rd_count(rc1), .timeup_out(tu1), .expired(exp1), .irq(irq1), .tick_overrun(ovr1)
    );

    // Overrun instance, DIVISOR = 2
    logic         rst2;
    logic [N-1:0] clr2, tu2, exp2;
    logic [1:0]   rd2;
    logic [W-1:0] rc2;
    logic         irq2, ovr2;
    timer_scheduler_if #(.NUM_TIMERS(N), .TS_W(W)) a2 ();
    timer_scheduler #(.NUM_TIMERS(N), .TS_W(W), .DIVISOR(2)) u_dut_ovr (
        .clk(clk), .reset_in(rst2), .arm(a2), .expired_clr(clr2), .rd_id(rd2),
        .rd_count(rc2), .timeup_out(tu2), .expired(exp2), .irq(irq2), .tick_overrun(ovr2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: m_pos = timer being swept this cycle, -1 when idle
    int           m_cyc;
    int           m_pos;
    bit           m_pend, m_ovr, m_irq;
    int           m_cnt [N];
    bit [N-1:0]   m_run, m_exp;
    int           m_rd;

    function automatic void model_step(input bit rst, input bit av, input int id,
                                       input int val, input bit [N-1:0] clr, input int rd);
        int         cnt_n [N];
        bit [N-1:0] run_n, exp_n;
        bit         tick, pend_n;
        int         pos_n;
        if (rst) begin
            m_cyc = 0; m_pos = -1; m_pend = 0; m_ovr = 0; m_irq = 0; m_rd = 0;
            m_run = '0; m_exp = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            return;
        end
        tick   = (m_cyc % DIV) == DIV - 1;
        cnt_n  = m_cnt;
        run_n  = m_run;
        exp_n  = m_exp & ~clr;
        pend_n = m_pend;
        pos_n  = m_pos;
        if (m_pos < 0 && av) begin
            cnt_n[id] = val;
            run_n[id] = (val != 0);
            exp_n[id] = (val == 0);
        end
        if (m_pos >= 0 && m_run[m_pos]) begin
            cnt_n[m_pos] = m_cnt[m_pos] - 1;
            if (cnt_n[m_pos] == 0) begin
                run_n[m_pos] = 0;
                exp_n[m_pos] = 1;
            end
        end
        if (m_pos < 0) begin
            if (tick || m_pend) begin pos_n = 0; pend_n = 0; end
        end else begin
            if (tick) begin
                if (m_pend) m_ovr = 1;
                else        pend_n = 1;
            end
            if (m_pos == N - 1) begin
                if (m_pend) begin pos_n = 0; pend_n = 0; end
                else        pos_n = -1;
            end else begin
                pos_n = m_pos + 1;
            end
        end
        m_irq  = (m_exp != 0);
        m_rd   = m_cnt[rd];
        m_cnt  = cnt_n;
        m_run  = run_n;
        m_exp  = exp_n;
        m_pend = pend_n;
        m_pos  = pos_n;
        m_cyc++;
    endfunction

    task automatic compare_all();
        chk("arm_ready", {31'd0, a1.arm_ready}, {31'd0, m_pos < 0});
        chk("timeup",    {28'd0, tu1},  {28'd0, m_run});
        chk("expired",   {28'd0, exp1}, {28'd0, m_exp});
        chk("irq",       {31'd0, irq1}, {31'd0, m_irq});
        chk("overrun",   {31'd0, ovr1}, {31'd0, m_ovr});
        chk("rd_count",  {24'd0, rc1},  m_rd);
    endtask

    // Called at a negedge; drives inputs, advances one cycle, checks at the next negedge
    task automatic step(input bit rst, input bit av, input int id, input int val,
                        input logic [N-1:0] clr, input int rd);
        rst1         = rst;
        a1.arm_valid = av;
        a1.arm_id    = id[1:0];
        a1.arm_value = val[7:0];
        clr1         = clr;
        rd1          = rd[1:0];
        @(posedge clk);
        model_step(rst, av, id, val, clr, rd);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_until(input int cyc, input int rd);
        int guard = 0;
        while (m_cyc < cyc && guard < 200) begin
            step(0, 0, 0, 0, '0, rd);
            guard++;
        end
        if (guard >= 200) chk("idle_until_budget", 32'(guard), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_exp, t_irq, lowcyc, g;
        rst1 = 1'b1; a1.arm_valid = 1'b0; a1.arm_id = '0; a1.arm_value = '0; clr1 = '0; rd1 = '0;
        rst2 = 1'b1; a2.arm_valid = 1'b0; a2.arm_id = '0; a2.arm_value = '0; clr2 = '0; rd2 = '0;

        // ---------------- DIVISOR=2 instance: overrun and mid-sweep reset ----------------
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst2 = 1'b0; a2.arm_valid = 1'b1; a2.arm_id = 2'd0; a2.arm_value = 8'd200;
        @(posedge clk);
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a2.arm_valid = 1'b0;
                chk("ovr_cfg_tu",    {28'd0, tu2}, 32'h1);
                chk("ovr_cfg_ready", {31'd0, a2.arm_ready}, 32'h1);
            end
            if (c == 2)  chk("ovr_cfg_sweep_ready", {31'd0, a2.arm_ready}, 32'h0);
            if (c == 5)  chk("ovr_before", {31'd0, ovr2}, 32'h0);
            if (c == 6)  chk("ovr_after",  {31'd0, ovr2}, 32'h1);
            if (c == 20) chk("ovr_one_dec_per_sweep", {24'd0, rc2}, 32'd195);
            if (c == 22) rst2 = 1'b1;
            if (c == 23) begin
                chk("midrst_tu",    {28'd0, tu2},  32'h0);
                chk("midrst_exp",   {28'd0, exp2}, 32'h0);
                chk("midrst_irq",   {31'd0, irq2}, 32'h0);
                chk("midrst_ovr",   {31'd0, ovr2}, 32'h0);
                chk("midrst_rd",    {24'd0, rc2},  32'h0);
                chk("midrst_ready", {31'd0, a2.arm_ready}, 32'h1);
            end
            @(posedge clk);
        end
        @(negedge clk);

        // ---------------- Main instance: reset state ----------------
        step(1, 0, 0, 0, '0, 0);
        step(1, 0, 0, 0, '0, 0);
        chk("rst_ready", {31'd0, a1.arm_ready}, 32'h1);
        chk("rst_exp",   {28'd0, exp1}, 32'h0);
        chk("rst_rd",    {24'd0, rc1},  32'h0);

        // Arm id0=3 in cycle 0; expiry lands during the third tick's sweep
        step(0, 1, 0, 3, '0, 0);
        chk("arm0_tu", {28'd0, tu1}, 32'h1);
        t_exp = -1; t_irq = -1;
        while (m_cyc < 30) begin
            step(0, 0, 0, 0, '0, 0);
            if (t_exp < 0 && exp1[0]) t_exp = m_cyc;
            if (t_irq < 0 && irq1)    t_irq = m_cyc;
            if (m_cyc == 5)  chk("rd0_3", {24'd0, rc1}, 32'd3);
            if (m_cyc == 12) chk("rd0_2", {24'd0, rc1}, 32'd2);
            if (m_cyc == 20) chk("rd0_1", {24'd0, rc1}, 32'd1);
            if (m_cyc == 26) chk("rd0_0", {24'd0, rc1}, 32'd0);
        end
        chk("exp0_cycle", 32'(t_exp), 32'd25);
        chk("irq_cycle",  32'(t_irq), 32'd26);

        // Consecutive arms id1=2, id3=1 (second one shares its cycle with a tick)
        step(0, 1, 1, 2, 4'b0001, 0);
        step(0, 1, 3, 1, '0, 2);
        idle_until(36, 2);
        chk("exp_tick1", {28'd0, exp1}, 32'b1000);
        idle_until(44, 2);
        chk("exp_tick2", {28'd0, exp1}, 32'b1010);
        chk("id2_untouched", {24'd0, rc1}, 32'd0);

        // Immediate expiry on zero, then clear racing a sweep expiry
        step(0, 1, 2, 0, '0, 0);
        chk("imm_exp", {31'd0, exp1[2]}, 32'h1);
        chk("imm_tu",  {31'd0, tu1[2]},  32'h0);
        step(0, 1, 2, 1, '0, 0);
        idle_until(50, 0);
        step(0, 0, 0, 0, 4'b0100, 0);
        chk("clr_vs_set", {31'd0, exp1[2]}, 32'h1);

        // Hold arm_valid across a whole sweep
        idle_until(56, 1);
        lowcyc = 0; g = 0;
        while (a1.arm_ready == 1'b0 && g < 20) begin
            lowcyc++;
            step(0, 1, 1, 7, '0, 1);
            g++;
        end
        chk("hold_low_cycles", 32'(lowcyc), 32'd4);
        step(0, 1, 1, 7, '0, 1);
        chk("hold_tu1", {31'd0, tu1[1]}, 32'h1);
        step(0, 0, 0, 0, '0, 1);
        chk("hold_rd", {24'd0, rc1}, 32'd7);

        // Restart a running timer
        step(0, 1, 0, 2, '0, 0);
        idle_until(68, 0);
        step(0, 1, 0, 5, '0, 0);
        idle_until(74, 0);
        chk("rearm_rd",    {24'd0, rc1},     32'd4);
        chk("rearm_noexp", {31'd0, exp1[0]}, 32'h0);

        // Randomized traffic including occasional resets
        for (int i = 0; i < 800; i++) begin
            bit         r_rst, r_av;
            int         r_id, r_val, r_rd;
            logic [N-1:0] r_clr;
            r_rst = ($urandom_range(0, 99) == 0);
            r_av  = ($urandom_range(0, 2) == 0);
            r_id  = $urandom_range(0, N - 1);
            r_val = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            r_clr = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            r_rd  = $urandom_range(0, N - 1);
            step(r_rst, r_av, r_id, r_val, r_clr, r_rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
